// File: rtl/reg_ascii_snapshot.sv
// Takes one snapshot per video frame of the CPU registers and every RAM word, and presents each bit as
// an ASCII '0'/'1' character. The output buses change only at commit, which happens inside VSYNC.
module reg_ascii_snapshot #(
    parameter int         RAM_WORDS = 16,
    parameter logic [7:0] CHAR_0    = 8'h30
) (
    input  logic                         clk_50mhz,
    input  logic                         reset_n,
    input  logic                         vsync,
    input  logic                         hold,
    input  logic [3:0]                   pc,
    input  logic [3:0]                   mar,
    input  logic [7:0]                   ir,
    input  logic [7:0]                   acc,
    input  logic [7:0]                   alu,
    input  logic [7:0]                   breg,
    input  logic [7:0]                   out_reg,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    input  logic [7:0]                   ram_data,
    output logic [31:0]                  pc_ascii,
    output logic [31:0]                  mar_ascii,
    output logic [63:0]                  ir_ascii,
    output logic [63:0]                  acc_ascii,
    output logic [63:0]                  alu_ascii,
    output logic [63:0]                  breg_ascii,
    output logic [63:0]                  output_reg_ascii,
    output logic [64*RAM_WORDS-1:0]      ram_ascii,
    output logic                         busy,
    output logic                         update
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(RAM_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_RAM_RD,
        ST_COMMIT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic vs_meta_q, vs_meta_d;
    logic vs_s_q, vs_s_d;
    logic vs_d_q, vs_d_d;
    logic update_q, update_d;
    logic trigger;
    logic [AW-1:0] wr_idx;

    // Shadow copies taken in CAPTURE, and the registered values that are on display
    logic [3:0] pc_sh_q, pc_sh_d, mar_sh_q, mar_sh_d;
    logic [7:0] ir_sh_q, ir_sh_d, acc_sh_q, acc_sh_d, alu_sh_q, alu_sh_d;
    logic [7:0] breg_sh_q, breg_sh_d, out_sh_q, out_sh_d;
    logic [3:0] pc_disp_q, pc_disp_d, mar_disp_q, mar_disp_d;
    logic [7:0] ir_disp_q, ir_disp_d, acc_disp_q, acc_disp_d, alu_disp_q, alu_disp_d;
    logic [7:0] breg_disp_q, breg_disp_d, out_disp_q, out_disp_d;

    logic [7:0] ram_buf_q  [RAM_WORDS];
    logic [7:0] ram_buf_d  [RAM_WORDS];
    logic [7:0] ram_disp_q [RAM_WORDS];
    logic [7:0] ram_disp_d [RAM_WORDS];
    logic [8*RAM_WORDS-1:0] ram_flat;

    // Two-flop synchronizer, then one more flop so the falling edge of VSYNC can be detected
    always_comb begin
        vs_meta_d = vsync;
        vs_s_d    = vs_meta_q;
        vs_d_d    = vs_s_q;
    end

    assign trigger = vs_d_q & ~vs_s_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        update_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A trigger that arrives while hold is high is dropped, not queued
                if (trigger && !hold) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                k_d     = '0;
                state_d = ST_RAM_RD;
            end
            ST_RAM_RD: begin
                if (k_q == CW'(RAM_WORDS)) begin
                    state_d = ST_COMMIT;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_COMMIT: begin
                k_d      = '0;
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign update   = update_q;
    assign ram_addr = (state_q == ST_RAM_RD && k_q < CW'(RAM_WORDS)) ? k_q[AW-1:0] : '0;

    // The RAM answers one cycle late, so data read in R_k belongs to word k-1
    assign wr_idx = AW'(k_q - CW'(1));

    always_comb begin
        pc_sh_d   = pc_sh_q;
        mar_sh_d  = mar_sh_q;
        ir_sh_d   = ir_sh_q;
        acc_sh_d  = acc_sh_q;
        alu_sh_d  = alu_sh_q;
        breg_sh_d = breg_sh_q;
        out_sh_d  = out_sh_q;
        ram_buf_d = ram_buf_q;
        if (state_q == ST_CAPTURE) begin
            pc_sh_d   = pc;
            mar_sh_d  = mar;
            ir_sh_d   = ir;
            acc_sh_d  = acc;
            alu_sh_d  = alu;
            breg_sh_d = breg;
            out_sh_d  = out_reg;
        end
        if (state_q == ST_RAM_RD && k_q != '0) begin
            ram_buf_d[wr_idx] = ram_data;
        end
    end

    always_comb begin
        pc_disp_d   = pc_disp_q;
        mar_disp_d  = mar_disp_q;
        ir_disp_d   = ir_disp_q;
        acc_disp_d  = acc_disp_q;
        alu_disp_d  = alu_disp_q;
        breg_disp_d = breg_disp_q;
        out_disp_d  = out_disp_q;
        ram_disp_d  = ram_disp_q;
        if (state_q == ST_COMMIT) begin
            pc_disp_d   = pc_sh_q;
            mar_disp_d  = mar_sh_q;
            ir_disp_d   = ir_sh_q;
            acc_disp_d  = acc_sh_q;
            alu_disp_d  = alu_sh_q;
            breg_disp_d = breg_sh_q;
            out_disp_d  = out_sh_q;
            ram_disp_d  = ram_buf_q;
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            update_q  <= 1'b0;
            vs_meta_q <= 1'b1;
            vs_s_q    <= 1'b1;
            vs_d_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            update_q  <= update_d;
            vs_meta_q <= vs_meta_d;
            vs_s_q    <= vs_s_d;
            vs_d_q    <= vs_d_d;
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            pc_sh_q     <= '0;
            mar_sh_q    <= '0;
            ir_sh_q     <= '0;
            acc_sh_q    <= '0;
            alu_sh_q    <= '0;
            breg_sh_q   <= '0;
            out_sh_q    <= '0;
            pc_disp_q   <= '0;
            mar_disp_q  <= '0;
            ir_disp_q   <= '0;
            acc_disp_q  <= '0;
            alu_disp_q  <= '0;
            breg_disp_q <= '0;
            out_disp_q  <= '0;
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram_buf_q[i]  <= '0;
                ram_disp_q[i] <= '0;
            end
        end else begin
            pc_sh_q     <= pc_sh_d;
            mar_sh_q    <= mar_sh_d;
            ir_sh_q     <= ir_sh_d;
            acc_sh_q    <= acc_sh_d;
            alu_sh_q    <= alu_sh_d;
            breg_sh_q   <= breg_sh_d;
            out_sh_q    <= out_sh_d;
            pc_disp_q   <= pc_disp_d;
            mar_disp_q  <= mar_disp_d;
            ir_disp_q   <= ir_disp_d;
            acc_disp_q  <= acc_disp_d;
            alu_disp_q  <= alu_disp_d;
            breg_disp_q <= breg_disp_d;
            out_disp_q  <= out_disp_d;
            ram_buf_q   <= ram_buf_d;
            ram_disp_q  <= ram_disp_d;
        end
    end

    function automatic logic [7:0] to_char(input logic b);
        return CHAR_0 + {7'b0, b};
    endfunction

    // The display registers hold raw bits, and each bit is mapped to its character combinationally
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign pc_ascii[8*gi +: 8]  = to_char(pc_disp_q[gi]);
            assign mar_ascii[8*gi +: 8] = to_char(mar_disp_q[gi]);
        end
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign ir_ascii[8*gi +: 8]         = to_char(ir_disp_q[gi]);
            assign acc_ascii[8*gi +: 8]        = to_char(acc_disp_q[gi]);
            assign alu_ascii[8*gi +: 8]        = to_char(alu_disp_q[gi]);
            assign breg_ascii[8*gi +: 8]       = to_char(breg_disp_q[gi]);
            assign output_reg_ascii[8*gi +: 8] = to_char(out_disp_q[gi]);
        end
        for (gi = 0; gi < RAM_WORDS; gi++) begin : g_ram_word
            assign ram_flat[8*gi +: 8] = ram_disp_q[gi];
        end
        for (gi = 0; gi < 8*RAM_WORDS; gi++) begin : g_ram_char
            assign ram_ascii[8*gi +: 8] = to_char(ram_flat[gi]);
        end
    endgenerate

endmodule

// File: doc/reg_ascii_snapshot.md
# reg_ascii_snapshot

Upstream feeder for the VGA register display. It captures the SAP-style CPU register values and all 16 RAM words once per video frame, starting at the VSYNC assertion edge. It converts every bit to an ASCII '0'/'1' character. It then presents frame-stable ASCII buses that the display stage renders with its 8x16 font. Outputs change only during vertical sync, so text never tears mid-frame.

## Interface
Parameters:
- RAM_WORDS, 16, number of RAM locations scanned (address width 4).
- CHAR_0, 8'h30, ASCII code emitted for a 0 bit; CHAR_1 = CHAR_0 + 1.

Ports:
- clk_50mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  active-low VSYNC from the display stage; asynchronous to this block's logic and double-synchronized internally.
- hold  in  1  when high, new snapshots are not started and outputs stay frozen.
- pc, mar  in  4 each  CPU register values.
- ir, acc, alu, breg, out_reg  in  8 each  CPU register values.
- ram_addr  out  4  RAM read address (read-only debug port).
- ram_data  in  8  RAM read data, valid exactly 1 cycle after ram_addr.
- pc_ascii, mar_ascii  out  32 each  4 characters; character for bit 3 in [31:24], bit 0 in [7:0].
- ir_ascii, acc_ascii, alu_ascii, breg_ascii, output_reg_ascii  out  64 each  8 characters; MSB character in [63:56].
- ram_ascii  out  1024  word k occupies [64k+63:64k], MSB character first.
- busy  out  1  high while a snapshot is in progress.
- update  out  1  one-cycle pulse coincident with the new output values.

## Operation
- Sync: vsync passes through 2 flops to give vs_s, then 1 more flop to give vs_d. The trigger is vs_d=1 and vs_s=0, i.e. the falling edge.
- FSM states: IDLE, CAPTURE, RAM_RD, COMMIT.
- IDLE: on trigger with hold=0, go to CAPTURE. A trigger with hold=1 is discarded and not remembered.
- CAPTURE (1 cycle): latch pc, mar, ir, acc, alu, breg and out_reg into shadow registers. Set the RAM counter k to 0. Go to RAM_RD.
- RAM_RD (17 cycles, R0..R16):
  - ram_addr = k during R_k for k = 0..15.
  - During R_{k+1}, ram_data is converted to 8 characters and stored in working buffer word k.
  - After R16, go to COMMIT.
- COMMIT (1 cycle): all register buses load the converted shadow values, and ram_ascii loads the working buffer, at the same edge. update is registered high for the following cycle. Go to IDLE.
- Conversion rule: each bit b produces the character CHAR_0 + b. There is no other formatting.
- Triggers arriving while busy=1 are ignored. hold going high mid-snapshot does not abort the snapshot.
- ram_addr is driven to 0 outside RAM_RD.

## Timing
- Reset: state is IDLE, busy=0, update=0, ram_addr=0. Every output character is 8'h30, i.e. all buses show '0'. All sync flops reset to 1 (vsync inactive).
- Latency from the vsync pin falling edge to the CAPTURE cycle is 3-4 clocks, depending on sync phase.
- A snapshot lasts 19 cycles from CAPTURE through COMMIT, with busy high for all 19.
- update and the new outputs appear in the cycle after COMMIT.
- At the 50 MHz clock, VSYNC is low for 2 lines (about 3200 clocks). The snapshot therefore completes well inside the VSYNC pulse.
- Register inputs are sampled in the CAPTURE cycle only. RAM word k is sampled at the end of the cycle in which address k is presented, i.e. during R_k.
- Outputs are constant between consecutive update pulses.
- When reset is asserted mid-snapshot, the FSM aborts immediately to IDLE and all outputs revert to their reset values. The partial working buffer is never committed.
- The ram_addr sequence wraps from 15 to 0 only via the state exit; there is never an out-of-range address.

## Test plan
- Reset check: assert reset_n=0, then release it. Required: all 1024+384 output bits form 8'h30 characters, busy=0, update=0, ram_addr=0.
- Basic snapshot:
  - Stimulus: pc=4'hA, ir=8'hC3, acc=8'h01, and RAM word k = k*17 (16 words, 1-cycle latency model); drive vsync 1->0.
  - Required: pc_ascii="1010", ir_ascii="11000011", acc_ascii="00000001", ram_ascii word 15 = "11111111", word 1 = "00010001".
  - Required: update pulses exactly once; busy is high for 19 cycles; ram_addr steps 0..15 one per cycle.
- Input change after CAPTURE: change acc to 8'hFF one cycle after CAPTURE. Required: acc_ascii still shows the captured value until the next frame.
- Hold: hold=1 across a vsync falling edge. Required: busy stays 0 and no update occurs. After setting hold=0, the next falling edge produces an update.
- Retrigger while busy: toggle vsync high then low again 5 cycles into RAM_RD. Required: a single update only, with the RAM scan unchanged.
- Reset mid-scan: pull reset_n low at R8. Required: busy=0 immediately, outputs are all '0', and no update pulse occurs. The next vsync edge produces a complete, correct snapshot.
